// File: rtl/matrix_fb.sv
// Double-buffered 1-bit-per-colour HUB75 framebuffer.
// Host writes the back bank; the scan driver reads the front bank; swaps land on frame_end.
module matrix_fb #(
    parameter int COLS = 32,
    parameter int ROWS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_x,
    input  logic [4:0] wr_y,
    input  logic [2:0] wr_rgb,
    input  logic       clear_req,
    output logic       clear_busy,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic       front_bank,
    input  logic       frame_end,
    input  logic       rd_en,
    input  logic [3:0] rd_row,
    input  logic [4:0] rd_col,
    output logic       rd_valid,
    output logic [1:0] rd_r,
    output logic [1:0] rd_g,
    output logic [1:0] rd_b
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS / 2);
    localparam int AW    = ROW_W + COL_W;
    localparam int DEPTH = (ROWS / 2) * COLS;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [2:0] top_mem [2][DEPTH];
    logic [2:0] bot_mem [2][DEPTH];

    logic          back;
    logic          wr_fire;
    logic          clr_we;
    logic          swap_exec;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [2:0]    top_rd;
    logic [2:0]    bot_rd;

    assign back      = ~front_bank;
    assign wr_fire   = wr_valid && wr_ready;
    assign clr_we    = (state_q == CLEAR);
    assign swap_exec = swap_pending && frame_end && (state_q == IDLE);
    assign wr_idx    = {wr_y[ROW_W-1:0], wr_x};
    assign rd_idx    = {rd_row, rd_col};
    assign top_rd    = top_mem[front_bank][rd_idx];
    assign bot_rd    = bot_mem[front_bank][rd_idx];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_ready   = 1'b0;
        clear_busy = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                clear_busy = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            front_bank   <= front_bank ^ swap_exec;
            // A request landing with an executing swap arms the next one.
            swap_pending <= swap_req | (swap_pending & ~swap_exec);
        end
    end

    // Clear and host writes never coincide: wr_ready is low in CLEAR.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            top_mem[back][cnt_q] <= '0;
            bot_mem[back][cnt_q] <= '0;
        end else if (wr_fire) begin
            if (wr_y[ROW_W]) bot_mem[back][wr_idx] <= wr_rgb;
            else             top_mem[back][wr_idx] <= wr_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_r     <= '0;
            rd_g     <= '0;
            rd_b     <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_r <= {bot_rd[2], top_rd[2]};
                rd_g <= {bot_rd[1], top_rd[1]};
                rd_b <= {bot_rd[0], top_rd[0]};
            end
        end
    end
endmodule

// File: tb/tb_matrix_fb.sv
// Scoreboard bench for matrix_fb: reads push expected pixel pairs,
// a monitor pops and compares whenever rd_valid is seen.
module tb_matrix_fb;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] wr_x;
    logic [4:0] wr_y;
    logic [2:0] wr_rgb;
    logic       clear_req;
    logic       clear_busy;
    logic       swap_req;
    logic       swap_pending;
    logic       front_bank;
    logic       frame_end;
    logic       rd_en;
    logic [3:0] rd_row;
    logic [4:0] rd_col;
    logic       rd_valid;
    logic [1:0] rd_r;
    logic [1:0] rd_g;
    logic [1:0] rd_b;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q [$];

    matrix_fb dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .swap_req(swap_req), .swap_pending(swap_pending),
        .front_bank(front_bank), .frame_end(frame_end),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_r(rd_r), .rd_g(rd_g), .rd_b(rd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {r1,r0,g1,g0,b1,b0} with bit1 = bottom, bit0 = top
    function automatic logic [5:0] pair(input logic [2:0] t, input logic [2:0] b);
        return {b[2], t[2], b[1], t[1], b[0], t[0]};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    chk("rd_data", int'({rd_r, rd_g, rd_b}), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic wr(input int x, input int y, input logic [2:0] rgb);
        wr_valid = 1'b1;
        wr_x     = 5'(x);
        wr_y     = 5'(y);
        wr_rgb   = rgb;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic rd(input int row, input int col, input logic [5:0] e);
        rd_en  = 1'b1;
        rd_row = 4'(row);
        rd_col = 5'(col);
        exp_q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_swap_frame();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req  = 1'b0;
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    task automatic wait_clear_done(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (clear_busy && n < 2000) begin
            n++;
            if (wr_ready) bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int bad;
        rst = 1'b0;
        wr_valid = 0; wr_x = 0; wr_y = 0; wr_rgb = 0;
        clear_req = 0; swap_req = 0; frame_end = 0;
        rd_en = 0; rd_row = 0; rd_col = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_front", int'(front_bank), 0);
        chk("rst_pending", int'(swap_pending), 0);
        chk("rst_busy", int'(clear_busy), 0);
        chk("rst_rd", int'({rd_valid, rd_r, rd_g, rd_b}), 0);

        // 1: basic write / swap / read
        wr(3, 2, 3'b101);
        wr(3, 18, 3'b010);
        pulse_swap_frame();
        chk("t1_front", int'(front_bank), 1);
        rd(2, 3, 6'b01_10_01);

        // 2: swap held off until frame_end; preload bank 0 meanwhile
        wr(5, 1, 3'b110);
        wr(5, 17, 3'b001);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        repeat (100) @(negedge clk);
        chk("t2_front_hold", int'(front_bank), 1);
        chk("t2_pending_hold", int'(swap_pending), 1);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk("t2_front_swap", int'(front_bank), 0);
        chk("t2_pending_clr", int'(swap_pending), 0);

        // 3: back-bank writes invisible until swap; read during swap sees old bank
        rd(1, 5, pair(3'b110, 3'b001));
        wr(5, 1, 3'b011);
        wr(5, 17, 3'b100);
        rd(1, 5, pair(3'b110, 3'b001));
        swap_req = 1'b1;
        @(negedge clk);
        swap_req  = 1'b0;
        frame_end = 1'b1;
        rd(1, 5, pair(3'b110, 3'b001));
        frame_end = 1'b0;
        chk("t3_front", int'(front_bank), 1);
        rd(1, 5, pair(3'b011, 3'b100));
        rd(2, 3, 6'b01_10_01);

        // 4: fill back bank (0) with 111, clear, swap, everything reads zero
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                wr(x, y, 3'b111);
        clear_req = 1'b1;
        wr_valid  = 1'b1;
        wr_x = 5'd7; wr_y = 5'd7; wr_rgb = 3'b111;
        @(negedge clk);
        clear_req = 1'b0;
        wr_valid  = 1'b0;
        wait_clear_done(n, bad);
        chk("t4_busy_cycles", n, 512);
        chk("t4_ready_low", bad, 0);
        chk("t4_ready_back", int'(wr_ready), 1);
        pulse_swap_frame();
        chk("t4_front", int'(front_bank), 0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++) begin
                rd_en  = 1'b1;
                rd_row = 4'(r);
                rd_col = 5'(c);
                exp_q.push_back(6'b0);
                @(negedge clk);
            end
        rd_en = 1'b0;

        // 5: frame_end during clear does not swap
        clear_req = 1'b1;
        swap_req  = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        swap_req  = 1'b0;
        repeat (99) @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk("t5_no_swap", int'(front_bank), 0);
        chk("t5_pending", int'(swap_pending), 1);
        chk("t5_busy", int'(clear_busy), 1);
        wait_clear_done(n, bad);
        chk("t5_clear_done", int'(n < 2000), 1);
        chk("t5_still_front", int'(front_bank), 0);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        chk("t5_swap", int'(front_bank), 1);
        chk("t5_pending_clr", int'(swap_pending), 0);

        // 6: reset in the middle of a clear with swap pending
        clear_req = 1'b1;
        swap_req  = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        swap_req  = 1'b0;
        repeat (199) @(negedge clk);
        chk("t6_busy_pre", int'(clear_busy), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready", int'(wr_ready), 1);
        chk("t6_busy", int'(clear_busy), 0);
        chk("t6_front", int'(front_bank), 0);
        chk("t6_pending", int'(swap_pending), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_busy_after", int'(clear_busy), 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
